// File: rtl/equalizer_nband_mixer.sv
// N-band equalizer mixer: sums band[k]*gain[k] with one multiply per cycle and saturates the
// result. Gains are double-buffered (shadow/active); a commit is applied on the next sample accept.
module equalizer_nband_mixer #(
   parameter int unsigned NBANDS = 8,
   parameter int unsigned DW     = 16,
   parameter int unsigned GW     = 8,
   parameter int unsigned GFRAC  = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NBANDS*DW-1:0]          x_band,
   input  logic                          bypass,
   input  logic                          gain_wr_en,
   input  logic [$clog2(NBANDS)-1:0]     gain_addr,
   input  logic signed [GW-1:0]          gain_wr_data,
   input  logic                          gain_commit,
   output logic                          gain_pending,
   output logic signed [DW-1:0]          y,
   output logic                          out_valid,
   output logic                          sat_flag,
   input  logic                          sat_clr
);

   localparam int unsigned IW = $clog2(NBANDS);
   localparam int unsigned PW = DW + GW;
   localparam int unsigned AW = PW + IW;

   localparam logic signed [GW-1:0] GUnity = GW'(1 << GFRAC);
   localparam logic signed [AW-1:0] AccMax = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] AccMin = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
   localparam logic signed [DW-1:0] YMax   = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] YMin   = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

   state_e                state_q, state_d;
   logic signed [DW-1:0]  x_q [NBANDS];
   logic signed [DW-1:0]  x_d [NBANDS];
   logic signed [GW-1:0]  shadow_q [NBANDS];
   logic signed [GW-1:0]  shadow_d [NBANDS];
   logic signed [GW-1:0]  active_q [NBANDS];
   logic signed [GW-1:0]  active_d [NBANDS];
   logic                  bypass_q, bypass_d;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic signed [DW-1:0]  y_q, y_d;
   logic                  out_valid_q, out_valid_d;
   logic                  sat_q, sat_d;
   logic                  pending_q, pending_d;

   logic signed [DW-1:0]  band;
   logic signed [GW-1:0]  g_eff;
   logic signed [PW-1:0]  prod;
   logic signed [AW-1:0]  shifted;

   assign band    = x_q[idx_q];
   assign g_eff   = bypass_q ? GUnity : active_q[idx_q];
   assign prod    = PW'(band) * PW'(g_eff);
   assign shifted = acc_q >>> GFRAC;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      bypass_d    = bypass_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      y_d         = y_q;
      out_valid_d = 1'b0;
      sat_d       = sat_q & ~sat_clr;
      shadow_d    = shadow_q;
      active_d    = active_q;
      pending_d   = pending_q | gain_commit;

      if (gain_wr_en && (32'(gain_addr) < NBANDS)) begin
         shadow_d[gain_addr] = gain_wr_data;
      end

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               for (int k = 0; k < int'(NBANDS); k++) begin
                  x_d[k] = x_band[k*DW +: DW];
               end
               bypass_d = bypass;
               acc_d    = '0;
               idx_d    = '0;
               state_d  = StAcc;
               // Transfer reads shadow_q, so a same-cycle shadow write stays in shadow only.
               if (pending_d) begin
                  active_d  = shadow_q;
                  pending_d = 1'b0;
               end
            end
         end
         StAcc: begin
            acc_d = acc_q + AW'(prod);
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(NBANDS - 1)) begin
               state_d = StOut;
            end
         end
         StOut: begin
            out_valid_d = 1'b1;
            state_d     = StIdle;
            if (shifted > AccMax) begin
               y_d   = YMax;
               sat_d = 1'b1;
            end else if (shifted < AccMin) begin
               y_d   = YMin;
               sat_d = 1'b1;
            end else begin
               y_d = shifted[DW-1:0];
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bypass_q    <= 1'b0;
         acc_q       <= '0;
         idx_q       <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         pending_q   <= 1'b0;
         for (int k = 0; k < int'(NBANDS); k++) begin
            x_q[k]      <= '0;
            shadow_q[k] <= GUnity;
            active_q[k] <= GUnity;
         end
      end else begin
         state_q     <= state_d;
         bypass_q    <= bypass_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
         sat_q       <= sat_d;
         pending_q   <= pending_d;
         x_q         <= x_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
      end
   end

   assign in_ready     = (state_q == StIdle);
   assign gain_pending = pending_q;
   assign y            = y_q;
   assign out_valid    = out_valid_q;
   assign sat_flag     = sat_q;

endmodule

// File: tb/tb_equalizer_nband_mixer.sv
// Bench for equalizer_nband_mixer: directed and random samples checked against a plain-arithmetic
// model of the gain banks, the weighted sum and saturation.
module tb_equalizer_nband_mixer;

   localparam int NB    = 8;
   localparam int DW    = 16;
   localparam int GW    = 8;
   localparam int GFRAC = 0;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic [NB*DW-1:0]         x_band = '0;
   logic                     bypass = 1'b0;
   logic                     gain_wr_en = 1'b0;
   logic [$clog2(NB)-1:0]    gain_addr = '0;
   logic signed [GW-1:0]     gain_wr_data = '0;
   logic                     gain_commit = 1'b0;
   logic                     gain_pending;
   logic signed [DW-1:0]     y;
   logic                     out_valid;
   logic                     sat_flag;
   logic                     sat_clr = 1'b0;

   always #5 clk = ~clk;

   equalizer_nband_mixer #(
      .NBANDS(NB),
      .DW    (DW),
      .GW    (GW),
      .GFRAC (GFRAC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .x_band      (x_band),
      .bypass      (bypass),
      .gain_wr_en  (gain_wr_en),
      .gain_addr   (gain_addr),
      .gain_wr_data(gain_wr_data),
      .gain_commit (gain_commit),
      .gain_pending(gain_pending),
      .y           (y),
      .out_valid   (out_valid),
      .sat_flag    (sat_flag),
      .sat_clr     (sat_clr)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc = -100;

   // Reference model state
   int  shadow_m [NB];
   int  active_m [NB];
   bit  pending_m;
   bit  sat_m;
   int  bands [NB];
   logic signed [DW-1:0] y_prev;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NB; k++) begin
         shadow_m[k] = 1 << GFRAC;
         active_m[k] = 1 << GFRAC;
      end
      pending_m = 1'b0;
      sat_m     = 1'b0;
   endtask

   task automatic set_bands(input int v);
      for (int k = 0; k < NB; k++) bands[k] = v;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic write_gain(input int addr, input int data);
      gain_wr_en   = 1'b1;
      gain_addr    = addr[$clog2(NB)-1:0];
      gain_wr_data = data[GW-1:0];
      tick();
      gain_wr_en = 1'b0;
      shadow_m[addr] = data;
   endtask

   task automatic commit(input string tag);
      gain_commit = 1'b1;
      tick();
      gain_commit = 1'b0;
      pending_m   = 1'b1;
      chk({tag, " gain_pending after commit"}, gain_pending, pending_m);
   endtask

   // One sample through the DUT; a gain write set up by the caller lands in the accept cycle.
   task automatic run_sample(input string tag, input bit byp, input bit cmt, input bit hold,
                             input bit clr_at_out, input bit b2b_check);
      longint sum;
      longint exp_y;
      bit     ev;
      int     waited;
      bit     busy_ok;
      chk({tag, " in_ready before accept"}, in_ready, 1);
      for (int k = 0; k < NB; k++) x_band[k*DW +: DW] = 16'(bands[k]);
      bypass      = byp;
      gain_commit = cmt;
      in_valid    = 1'b1;
      if (pending_m || cmt) begin
         active_m  = shadow_m;
         pending_m = 1'b0;
      end
      if (gain_wr_en) shadow_m[int'(gain_addr)] = int'(gain_wr_data);
      sum = 0;
      for (int k = 0; k < NB; k++) begin
         sum += longint'(bands[k]) * longint'(byp ? (1 << GFRAC) : active_m[k]);
      end
      sum = sum >>> GFRAC;
      ev  = 1'b0;
      if (sum > 32767) begin
         exp_y = 32767;
         ev    = 1'b1;
      end else if (sum < -32768) begin
         exp_y = -32768;
         ev    = 1'b1;
      end else begin
         exp_y = sum;
      end
      tick();
      if (b2b_check) chk({tag, " accept spacing"}, cyc - last_acc, NB + 2);
      last_acc    = cyc;
      in_valid    = hold;
      gain_commit = 1'b0;
      gain_wr_en  = 1'b0;
      bypass      = ~byp;
      if (hold) x_band = {$urandom, $urandom, $urandom, $urandom};
      chk({tag, " gain_pending after accept"}, gain_pending, 0);
      waited  = 0;
      busy_ok = 1'b1;
      while (!out_valid && waited < 30) begin
         if (in_ready !== 1'b0) busy_ok = 1'b0;
         sat_clr = clr_at_out && (waited == NB);
         tick();
         waited++;
      end
      sat_clr = 1'b0;
      sat_m   = ev | (sat_m & ~clr_at_out);
      chk({tag, " in_ready low while busy"}, busy_ok, 1);
      chk({tag, " latency"}, waited, NB + 1);
      chk({tag, " y"}, y, exp_y);
      chk({tag, " sat_flag"}, sat_flag, sat_m);
      y_prev = y;
   endtask

   initial begin
      int n_out;
      model_reset();
      repeat (2) tick();
      do_reset();
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset y", y, 0);
      chk("reset sat_flag", sat_flag, 0);
      chk("reset gain_pending", gain_pending, 0);

      set_bands(100);
      run_sample("unity", 0, 0, 0, 0, 0);
      tick();
      chk("out_valid one cycle", out_valid, 0);
      chk("y holds", y, y_prev);

      write_gain(3, 4);
      run_sample("shadow only", 0, 0, 0, 0, 0);
      commit("g3");
      run_sample("committed g3", 0, 0, 0, 0, 0);

      set_bands(20000);
      run_sample("sat pos", 0, 0, 0, 0, 0);
      set_bands(-20000);
      run_sample("sat neg clr same cycle", 0, 0, 0, 1, 0);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      sat_m   = 1'b0;
      chk("sat_clr", sat_flag, 0);

      write_gain(0, -2);
      commit("g0");
      set_bands(0);
      bands[0] = 1000;
      run_sample("neg gain", 0, 0, 0, 0, 0);
      run_sample("bypass", 1, 0, 0, 0, 0);

      // Commit on the accept cycle plus a shadow write on the same edge.
      write_gain(1, 3);
      set_bands(10);
      gain_wr_en   = 1'b1;
      gain_addr    = 3'd1;
      gain_wr_data = 8'sd5;
      run_sample("commit at accept", 0, 1, 0, 0, 0);
      commit("late");
      run_sample("post-write shadow", 0, 0, 0, 0, 0);

      // in_valid held through ACC with other data; back-to-back accepts.
      set_bands(7);
      run_sample("hold a", 0, 0, 1, 0, 0);
      set_bands(-3);
      run_sample("hold b", 0, 0, 1, 0, 1);
      set_bands(50);
      run_sample("hold c", 0, 0, 0, 0, 1);

      // Reset in the middle of accumulation.
      write_gain(3, 4);
      commit("pre-reset");
      set_bands(100);
      for (int k = 0; k < NB; k++) x_band[k*DW +: DW] = 16'(bands[k]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      gain_commit = 1'b1;
      tick();
      gain_commit = 1'b0;
      repeat (2) tick();
      do_reset();
      n_out = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid) n_out++;
         tick();
      end
      chk("abort no out_valid", n_out, 0);
      chk("abort y", y, 0);
      chk("abort gain_pending", gain_pending, 0);
      run_sample("after reset", 0, 0, 0, 0, 0);

      for (int it = 0; it < 20; it++) begin
         int nw;
         nw = int'($urandom_range(0, 2));
         for (int w = 0; w < nw; w++) begin
            write_gain(int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 255)) - 128);
         end
         if ($urandom_range(0, 1) == 1) commit("rnd");
         for (int k = 0; k < NB; k++) begin
            bands[k] = (it % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768
                                     : int'($urandom_range(0, 400)) - 200;
         end
         if ($urandom_range(0, 3) == 0) begin
            gain_wr_en   = 1'b1;
            gain_addr    = 3'($urandom_range(0, NB - 1));
            gain_wr_data = 8'($urandom_range(0, 255));
         end
         run_sample("random", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0,
                    bit'($urandom_range(0, 1)), 0);
         if ($urandom_range(0, 2) == 0) begin
            sat_clr = 1'b1;
            tick();
            sat_clr = 1'b0;
            sat_m   = 1'b0;
            chk("random sat_clr", sat_flag, 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
